pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 15 +
 rtl/pwm_capture_in_sync.sv | 71 +++++++
 rtl/pwm_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared servo/PWM constants so the generator and the capture block agree on
// counter width, nominal servo period and the default loss timeout.
package pwm_capture_pkg;

    localparam int CNT_W           = 32;
    localparam int SERVO_PERIOD    = 2000000;
    localparam int DEFAULT_TIMEOUT = 4000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_in_sync.sv
// pwm_in_sync: 2-flop synchronizer for the external PWM, plus an optional
// glitch filter selected by PWM_CAPTURE_FILTER_EN.
module pwm_in_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic pclk_i,
    input  logic presetn_i,
    input  logic pwm_i,
    output logic sync_o,
    output logic sync_vld_o
);

    logic meta_q;
    logic stab_q;

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            meta_q <= 1'b0;
            stab_q <= 1'b0;
        end else begin
            meta_q <= pwm_i;
            stab_q <= meta_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int SETTLE = 2 + FILTER_LEN;
    localparam int FW     = $clog2(FILTER_LEN + 1);

    logic          filt_q;
    logic [FW-1:0] run_q;

    // run_q counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else if (stab_q == filt_q) begin
            run_q  <= '0;
        end else if (run_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= stab_q;
            run_q  <= '0;
        end else begin
            run_q  <= run_q + FW'(1);
        end
    end

    assign sync_o = filt_q;
`else
    localparam int SETTLE = 2;

    assign sync_o = stab_q;
`endif

    // The level after reset is a flop reset value, not the input; flag when the
    // pipeline holds real samples so a level that is already high is no "rise".
    localparam int SW = $clog2(2 + FILTER_LEN + 1);

    logic [SW-1:0] settle_q;

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            settle_q <= SW'(SETTLE);
        end else if (settle_q != '0) begin
            settle_q <= settle_q - SW'(1);
        end
    end

    assign sync_vld_o = (settle_q == '0);

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of pwm_in in PCLK
// cycles. Define PWM_CAPTURE_FILTER_EN to add a FILTER_LEN-sample glitch filter.
//
//   state  | meaning
//   S_IDLE | no reference rise yet (after reset or loss); waits for a rise
//   S_HIGH | input high; high_cnt and per_cnt both counting
//   S_LOW  | input low; per_cnt counting, next rise publishes
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int          FILTER_LEN = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             pwm_in,
    input  logic             capture_read,
    output logic [CNT_W-1:0] pulse_width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             new_sample,
    output logic             lost
);

    logic sync;
    logic sync_vld;

    pwm_in_sync #(
        .FILTER_LEN(FILTER_LEN)
    ) u_in_sync (
        .pclk_i    (PCLK),
        .presetn_i (PRESETn),
        .pwm_i     (pwm_in),
        .sync_o    (sync),
        .sync_vld_o(sync_vld)
    );

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             new_q, new_d;
    logic             lost_q, lost_d;
    logic             sync_prev_q;
    logic             prev_vld_q;

    logic rise;
    logic fall;
    logic timeout;
    logic publish;
    logic to_idle;

    assign rise    = sync & ~sync_prev_q & prev_vld_q;
    assign fall    = ~sync & sync_prev_q;
    assign timeout = (per_cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        per_cnt_d  = per_cnt_q;
        width_d    = width_q;
        period_d   = period_q;
        valid_d    = valid_q;
        new_d      = new_q;
        lost_d     = lost_q;
        publish    = 1'b0;
        to_idle    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d    = S_HIGH;
                    high_cnt_d = CNT_W'(1);
                    per_cnt_d  = CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (timeout) begin
                    to_idle = 1'b1;
                end else if (fall) begin
                    state_d   = S_LOW;
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                end else begin
                    high_cnt_d = high_cnt_q + CNT_W'(1);
                    per_cnt_d  = per_cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (timeout) begin
                    to_idle = 1'b1;
                end else if (rise) begin
                    publish    = 1'b1;
                    state_d    = S_HIGH;
                    high_cnt_d = CNT_W'(1);
                    per_cnt_d  = CNT_W'(1);
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (to_idle) begin
            state_d = S_IDLE;
            lost_d  = 1'b1;
            valid_d = 1'b0;
        end

        // A publish in the same cycle as a read keeps the flag set.
        if (publish) begin
            width_d  = high_cnt_q;
            period_d = per_cnt_q;
            valid_d  = 1'b1;
            new_d    = 1'b1;
            lost_d   = 1'b0;
        end else if (capture_read) begin
            new_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            high_cnt_q  <= '0;
            per_cnt_q   <= '0;
            width_q     <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            new_q       <= 1'b0;
            lost_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            prev_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            per_cnt_q   <= per_cnt_d;
            width_q     <= width_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            new_q       <= new_d;
            lost_q      <= lost_d;
            sync_prev_q <= sync;
            prev_vld_q  <= sync_vld;
        end
    end

    assign pulse_width = width_q;
    assign period      = period_q;
    assign valid       = valid_q;
    assign new_sample  = new_q;
    assign lost        = lost_q;

endmodule
